halt_dump_unit: RTL and testbench
=================================

HALT_DUMP_UNIT -- requirements
Module: halt_dump_unit

Interface
REQ-001 The block SHALL provide parameter MEM_WORDS, default 1024, meaning the number of 32-bit data-memory words dumped (power of two, 2..65536).
REQ-002 The block SHALL provide parameter VLEN, default 128, meaning the vector register width in bits (multiple of 32, 32..1024).
REQ-003 The block SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL provide port rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL provide port halt  input  1  CPU halt indication.
REQ-006 The block SHALL provide port reg_raddr  output  5  scalar register file read address.
REQ-007 The block SHALL provide port reg_rdata  input  32  scalar register read data, combinational from reg_raddr.
REQ-008 The block SHALL provide port vreg_raddr  output  5  vector register file read address.
REQ-009 The block SHALL provide port vreg_rdata  input  VLEN  vector register read data, combinational from vreg_raddr.
REQ-010 The block SHALL provide port mem_raddr  output  clog2(MEM_WORDS)  data-memory word read address.
REQ-011 The block SHALL provide port mem_rdata  input  32  memory read data, combinational from mem_raddr.
REQ-012 The block SHALL provide port dump_valid  output  1  the output beat is valid.
REQ-013 The block SHALL provide port dump_ready  input  1  the sink accepts the beat.
REQ-014 The block SHALL provide port dump_data  output  32  beat payload.
REQ-015 The block SHALL provide port dump_region  output  2  0 header, 1 scalar reg, 2 vector reg, 3 memory.
REQ-016 The block SHALL provide port dump_index  output  16  beat index within its region.
REQ-017 The block SHALL provide port dump_last  output  1  final beat of the dump.
REQ-018 The block SHALL provide ports busy and done  output  1 each  dump in progress / dump completed.

Function
REQ-019 States SHALL be IDLE, HEADER, REGS, VREGS, MEM and DONE, traversed only in that order.
REQ-020 In IDLE, a 32-bit cycle counter SHALL increment on every rising edge where halt is low, saturating at 0xFFFFFFFF.
REQ-021 A rising edge in IDLE with halt high SHALL freeze the counter, load the header beat (data=counter, region 0, index 0) and set dump_valid and busy.
REQ-022 A beat SHALL transfer on a rising edge where dump_valid and dump_ready are both high; in the same edge the next beat SHALL be loaded, giving 1 beat/cycle throughput.
REQ-023 While dump_valid is high and dump_ready is low, dump_data, dump_region, dump_index and dump_last SHALL hold stable.
REQ-024 REGS SHALL emit 32 beats, index i = 0..31, data = reg_rdata with reg_raddr = i; x0 SHALL be emitted as read, without being forced to zero.
REQ-025 VREGS SHALL emit 32*(VLEN/32) beats; beat index = r*(VLEN/32)+w carries bits [32w+31:32w] of vector register r, with w=0 first.
REQ-026 MEM SHALL emit MEM_WORDS beats, index a, data = mem_rdata with mem_raddr = a.
REQ-027 Read addresses SHALL select the beat being loaded, so the sampled data is correct at the loading edge.
REQ-028 dump_last SHALL be high only on memory beat MEM_WORDS-1.
REQ-029 After the last beat transfers: dump_valid 0, busy 0, done 1, state DONE until reset.
REQ-030 halt deasserting or re-asserting after the halt sampling edge SHALL NOT affect the dump or the frozen counter.
REQ-031 The total beat count SHALL be 33+32*(VLEN/32)+MEM_WORDS, which is 1185 at defaults.

Reset
REQ-032 While rst is low, all outputs SHALL be 0 immediately (asynchronous reset), the state SHALL be IDLE and the counter SHALL be 0, including when reset asserts mid-dump.
REQ-033 A dump aborted by reset SHALL NOT resume; a later halt SHALL start a complete dump from the header.

Verification
REQ-034 Reset check: hold rst low with random inputs -> all outputs 0; assert rst mid-cycle -> outputs clear without waiting for a clock edge.
REQ-035 Halt at the 10th edge after rst release, ready=1, reg model reg_rdata=0x100+addr -> header 9; reg beats 0x100..0x11F; 1185 beats in order; last on beat 1185; done set on the next edge.
REQ-036 Vector order: vreg 3 = 0x0D0C0B0A_09080706_05040302_01000000 -> region 2 indices 12..15 carry 0x01000000, 0x05040302, 0x09080706, 0x0D0C0B0A.
REQ-037 Backpressure: drive dump_ready randomly ~50% -> payload stable while stalled; scoreboard shows no lost or duplicated beats; 1185 transfers total.
REQ-038 One-cycle halt pulse, then halt toggled during MEM -> full dump completes with the header unchanged.
REQ-039 Assert reset at memory beat 500, release, halt at the 4th edge -> header 3; new full dump of 1185 beats; done only at its end.

Source files
------------

// File: rtl/halt_dump_unit_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : halt_dump_unit_if                                            |
// | Description : Dump output stream of halt_dump_unit. One beat carries a     |
// |               32-bit payload tagged with its region and index.             |
// | Signals     : dump_valid  beat valid (master -> slave)                     |
// |               dump_ready  sink accepts the beat (slave -> master)          |
// |               dump_data   32-bit beat payload                              |
// |               dump_region 0 header, 1 scalar reg, 2 vector reg, 3 memory   |
// |               dump_index  beat index within its region                     |
// |               dump_last   final beat of the dump                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface halt_dump_unit_if;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_data;
  logic [1:0]  dump_region;
  logic [15:0] dump_index;
  logic        dump_last;

  modport master (
    output dump_valid, dump_data, dump_region, dump_index, dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid, dump_data, dump_region, dump_index, dump_last,
    output dump_ready
  );
endinterface
`default_nettype wire

// File: rtl/halt_dump_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : halt_dump_unit                                               |
// | Description : Counts cycles until the CPU halts, then streams a dump:      |
// |               header (cycle count), 32 scalar registers, 32 vector         |
// |               registers split into 32-bit words (low word first) and       |
// |               MEM_WORDS data-memory words. One beat per cycle when ready.  |
// | Ports       : clk, rst (async, active low), halt                           |
// |               reg_raddr/reg_rdata    scalar register file read port        |
// |               vreg_raddr/vreg_rdata  vector register file read port        |
// |               mem_raddr/mem_rdata    data memory read port                 |
// |               dump                   valid/ready beat stream (master)      |
// |               busy, done             dump in progress / dump completed     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module halt_dump_unit #(
  parameter int MEM_WORDS = 1024,
  parameter int VLEN      = 128
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         halt,
  output logic [4:0]                        reg_raddr,
  input  wire logic [31:0]                  reg_rdata,
  output logic [4:0]                        vreg_raddr,
  input  wire logic [VLEN-1:0]              vreg_rdata,
  output logic [$clog2(MEM_WORDS)-1:0]      mem_raddr,
  input  wire logic [31:0]                  mem_rdata,
  halt_dump_unit_if.master                  dump,
  output logic                              busy,
  output logic                              done
);

  localparam int          AW       = $clog2(MEM_WORDS);
  localparam int          VW       = VLEN / 32;
  localparam logic [15:0] MEM_LAST = 16'(MEM_WORDS - 1);
  localparam logic [4:0]  VW_LAST  = 5'(VW - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_REGS   = 3'd2,
    S_VREGS  = 3'd3,
    S_MEM    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  // state_q/idx_q/vr_q/vw_q describe the beat currently presented on dump.
  state_t      state_q, state_d;
  logic [15:0] idx_q,   idx_d;
  logic [4:0]  vr_q,    vr_d;
  logic [4:0]  vw_q,    vw_d;
  logic [31:0] cnt_q,   cnt_d;
  logic [31:0] data_q,  data_d;

  // Position of the beat that would be loaded next.
  state_t      nxt_state;
  logic [15:0] nxt_idx;
  logic [4:0]  nxt_vr;
  logic [4:0]  nxt_vw;
  logic [31:0] nxt_data;
  logic [31:0] vword;
  logic        busy_w;
  logic        load;

  always_comb begin
    nxt_state = state_q;
    nxt_idx   = idx_q + 16'd1;
    nxt_vr    = vr_q;
    nxt_vw    = vw_q;
    case (state_q)
      S_IDLE: begin
        nxt_state = S_HEADER;
        nxt_idx   = '0;
        nxt_vr    = '0;
        nxt_vw    = '0;
      end
      S_HEADER: begin
        nxt_state = S_REGS;
        nxt_idx   = '0;
      end
      S_REGS: begin
        if (idx_q == 16'd31) begin
          nxt_state = S_VREGS;
          nxt_idx   = '0;
          nxt_vr    = '0;
          nxt_vw    = '0;
        end
      end
      S_VREGS: begin
        // Index keeps counting linearly (r*VW+w); r/w track the read port.
        if (vw_q == VW_LAST) begin
          nxt_vw = '0;
          if (vr_q == 5'd31) begin
            nxt_state = S_MEM;
            nxt_idx   = '0;
          end else begin
            nxt_vr = vr_q + 5'd1;
          end
        end else begin
          nxt_vw = vw_q + 5'd1;
        end
      end
      S_MEM: begin
        if (idx_q == MEM_LAST) begin
          nxt_state = S_DONE;
          nxt_idx   = '0;
        end
      end
      default: begin
        nxt_state = S_DONE;
        nxt_idx   = '0;
      end
    endcase
  end

  // Read addresses point at the beat about to be loaded so the register
  // file / memory data is already valid at the loading edge.
  assign reg_raddr  = (nxt_state == S_REGS)  ? nxt_idx[4:0]    : '0;
  assign vreg_raddr = (nxt_state == S_VREGS) ? nxt_vr          : '0;
  assign mem_raddr  = (nxt_state == S_MEM)   ? nxt_idx[AW-1:0] : '0;

  always_comb begin
    vword = '0;
    for (int k = 0; k < VW; k++) begin
      if (nxt_vw == 5'(k)) vword = vreg_rdata[32*k +: 32];
    end
  end

  always_comb begin
    case (nxt_state)
      S_HEADER: nxt_data = cnt_q;
      S_REGS:   nxt_data = reg_rdata;
      S_VREGS:  nxt_data = vword;
      S_MEM:    nxt_data = mem_rdata;
      default:  nxt_data = '0;
    endcase
  end

  assign busy_w = (state_q == S_HEADER) || (state_q == S_REGS) ||
                  (state_q == S_VREGS)  || (state_q == S_MEM);

  // In IDLE the halt sample starts the dump; afterwards halt is ignored.
  assign load = (state_q == S_IDLE) ? halt : (busy_w && dump.dump_ready);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vr_d    = vr_q;
    vw_d    = vw_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    if ((state_q == S_IDLE) && !halt && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_d = cnt_q + 32'd1;
    end
    if (load) begin
      state_d = nxt_state;
      idx_d   = nxt_idx;
      vr_d    = nxt_vr;
      vw_d    = nxt_vw;
      data_d  = nxt_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vr_q    <= '0;
      vw_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vr_q    <= vr_d;
      vw_q    <= vw_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    case (state_q)
      S_REGS:  dump.dump_region = 2'd1;
      S_VREGS: dump.dump_region = 2'd2;
      S_MEM:   dump.dump_region = 2'd3;
      default: dump.dump_region = 2'd0;
    endcase
  end

  assign dump.dump_valid = busy_w;
  assign dump.dump_data  = data_q;
  assign dump.dump_index = idx_q;
  assign dump.dump_last  = (state_q == S_MEM) && (idx_q == MEM_LAST);
  assign busy            = busy_w;
  assign done            = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_halt_dump_unit.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_halt_dump_unit                                            |
// | Description : Self-checking bench for halt_dump_unit. A beat-list model    |
// |               built from the register/memory contents predicts every       |
// |               beat; a negedge compare process checks the stream.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_halt_dump_unit;
  localparam int MEM_WORDS = 1024;
  localparam int VLEN      = 128;
  localparam int VW        = VLEN / 32;
  localparam int MEM_BASE  = 33 + 32 * VW;
  localparam int TOTAL     = MEM_BASE + MEM_WORDS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic halt = 1'b0;
  logic [4:0]      reg_raddr, vreg_raddr;
  logic [31:0]     reg_rdata, mem_rdata;
  logic [VLEN-1:0] vreg_rdata;
  logic [9:0]      mem_raddr;
  logic            busy, done;

  halt_dump_unit_if dif();

  logic [31:0]     mem_m  [MEM_WORDS];
  logic [VLEN-1:0] vreg_m [32];

  assign reg_rdata  = 32'h100 + {27'd0, reg_raddr};
  assign vreg_rdata = vreg_m[vreg_raddr];
  assign mem_rdata  = mem_m[mem_raddr];

  halt_dump_unit #(.MEM_WORDS(MEM_WORDS), .VLEN(VLEN)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .reg_raddr  (reg_raddr),
    .reg_rdata  (reg_rdata),
    .vreg_raddr (vreg_raddr),
    .vreg_rdata (vreg_rdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .dump       (dif.master),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Expected beat list (beat 0 payload is the header, held separately).
  logic [31:0] e_data [TOTAL];
  logic [1:0]  e_reg  [TOTAL];
  logic [15:0] e_idx  [TOTAL];

  task automatic build_expected();
    int p;
    p = 0;
    e_data[p] = '0; e_reg[p] = 2'd0; e_idx[p] = 16'd0; p++;
    for (int i = 0; i < 32; i++) begin
      e_data[p] = 32'h100 + i; e_reg[p] = 2'd1; e_idx[p] = 16'(i); p++;
    end
    for (int r = 0; r < 32; r++) begin
      for (int w = 0; w < VW; w++) begin
        e_data[p] = vreg_m[r][32*w +: 32]; e_reg[p] = 2'd2; e_idx[p] = 16'(r*VW + w); p++;
      end
    end
    for (int a = 0; a < MEM_WORDS; a++) begin
      e_data[p] = mem_m[a]; e_reg[p] = 2'd3; e_idx[p] = 16'(a); p++;
    end
  endtask

  // Model: cycle counter, header capture, and a pointer into the beat list.
  logic [31:0] m_cnt, m_hdr;
  logic        m_active, m_fin;
  int          m_ptr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt <= '0; m_hdr <= '0; m_active <= 1'b0; m_fin <= 1'b0; m_ptr <= 0;
    end else if (!m_active) begin
      if (halt) begin
        m_active <= 1'b1; m_hdr <= m_cnt; m_ptr <= 0;
      end else if (m_cnt != 32'hFFFF_FFFF) begin
        m_cnt <= m_cnt + 32'd1;
      end
    end else if (!m_fin && dif.dump_ready) begin
      if (m_ptr == TOTAL - 1) m_fin <= 1'b1;
      else                    m_ptr <= m_ptr + 1;
    end
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_xfer = 0;
  logic [31:0] cap_hdr, cap_reg5;
  logic [31:0] cap_v [4];
  logic        exp_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {dif.dump_valid, dif.dump_last, busy, done, dif.dump_region, dif.dump_index}, 64'd0);
    chk({tag, "_data"}, dif.dump_data, 64'd0);
    chk({tag, "_addr"}, {reg_raddr, vreg_raddr, mem_raddr}, 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk_zero("rst");
    end else begin
      exp_v = m_active && !m_fin;
      chk("valid", dif.dump_valid, exp_v);
      chk("busy", busy, exp_v);
      chk("done", done, m_fin);
      if (exp_v && dif.dump_valid) begin
        chk("data", dif.dump_data, (m_ptr == 0) ? m_hdr : e_data[m_ptr]);
        chk("region", dif.dump_region, e_reg[m_ptr]);
        chk("index", dif.dump_index, e_idx[m_ptr]);
        chk("last", dif.dump_last, m_ptr == TOTAL - 1);
        if (dif.dump_ready) begin
          n_xfer++;
          if (dif.dump_region == 2'd0) cap_hdr = dif.dump_data;
          if (dif.dump_region == 2'd1 && dif.dump_index == 16'd5) cap_reg5 = dif.dump_data;
          if (dif.dump_region == 2'd2 && dif.dump_index >= 16'd12 && dif.dump_index <= 16'd15)
            cap_v[dif.dump_index - 16'd12] = dif.dump_data;
        end
      end
    end
  end

  // Assert reset between clock edges, check outputs clear at once, release.
  task automatic do_reset_mid();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk_zero("rst_async");
    repeat (2) begin
      @(posedge clk); #1;
      halt = 1'($urandom); dif.dump_ready = 1'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b1; halt = 1'b0; n_xfer = 0; cap_hdr = 32'hDEAD_BEEF;
  endtask

  // Called just after reset release: halt is sampled on the n-th edge.
  task automatic start_halt(input int n);
    halt = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1 halt = 1'b1;
  endtask

  task automatic wait_fin(input int budget, input bit rnd_ready, input bit tog_halt, input string name);
    int k;
    k = 0;
    while (!m_fin && k < budget) begin
      @(posedge clk); #1;
      if (rnd_ready) dif.dump_ready = 1'($urandom);
      if (tog_halt && m_ptr >= MEM_BASE) halt = 1'($urandom);
      k++;
    end
    if (!m_fin) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: got no completion, required completion within %0d cycles", name, budget);
    end
  endtask

  initial begin
    dif.dump_ready = 1'b0;
    for (int i = 0; i < MEM_WORDS; i++) mem_m[i] = $urandom;
    for (int r = 0; r < 32; r++)
      for (int w = 0; w < VW; w++) vreg_m[r][32*w +: 32] = $urandom;
    vreg_m[3] = 128'h0D0C0B0A_09080706_05040302_01000000;
    build_expected();

    // Reset held with random inputs.
    repeat (20) begin
      @(posedge clk); #1;
      halt = 1'($urandom); dif.dump_ready = 1'($urandom);
    end

    // Full dump, ready always high, halt on the 10th edge.
    @(posedge clk); #1;
    rst = 1'b1; halt = 1'b0; dif.dump_ready = 1'b1; n_xfer = 0;
    start_halt(10);
    wait_fin(3000, 1'b0, 1'b0, "t1");
    chk("t1_header", cap_hdr, 64'd9);
    chk("t1_reg5", cap_reg5, 64'h105);
    chk("t1_vreg12", cap_v[0], 64'h0100_0000);
    chk("t1_vreg13", cap_v[1], 64'h0504_0302);
    chk("t1_vreg14", cap_v[2], 64'h0908_0706);
    chk("t1_vreg15", cap_v[3], 64'h0D0C_0B0A);
    chk("t1_xfers", n_xfer, 64'd1185);
    chk("t1_done", done, 64'd1);

    // Random backpressure.
    do_reset_mid();
    dif.dump_ready = 1'b1;
    start_halt(6);
    wait_fin(6000, 1'b1, 1'b0, "t2");
    chk("t2_header", cap_hdr, 64'd5);
    chk("t2_xfers", n_xfer, 64'd1185);

    // One-cycle halt pulse, then halt toggled during the memory region.
    do_reset_mid();
    dif.dump_ready = 1'b1;
    start_halt(5);
    @(posedge clk); #1 halt = 1'b0;
    wait_fin(3000, 1'b0, 1'b1, "t3");
    chk("t3_header", cap_hdr, 64'd4);
    chk("t3_xfers", n_xfer, 64'd1185);

    // Reset at memory beat 500, then a fresh dump.
    do_reset_mid();
    dif.dump_ready = 1'b1;
    start_halt(2);
    begin
      int k;
      k = 0;
      while (m_ptr < MEM_BASE + 500 && k < 3000) begin
        @(posedge clk); #1; k++;
      end
      chk("t4_reach_mem500", m_ptr >= MEM_BASE + 500, 64'd1);
    end
    do_reset_mid();
    dif.dump_ready = 1'b1;
    start_halt(4);
    wait_fin(3000, 1'b0, 1'b0, "t4");
    chk("t4_header", cap_hdr, 64'd3);
    chk("t4_xfers", n_xfer, 64'd1185);
    chk("t4_done", done, 64'd1);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
